// File: rtl/seq_code_pkg.sv
// Shared types and constants for the sequence-code checker.
// The monitored counter cycles through the four even-parity 3-bit codes
// 000 -> 011 -> 101 -> 110 -> 000; their position in that cycle is the phase index.
package seq_code_pkg;

    // Width of the decoded phase index (four phases)
    localparam int IDX_W = 2;

    // Legal counter codes, in cycle order, bit order {q2,q1,q0}
    localparam logic [2:0] CODE0 = 3'b000;
    localparam logic [2:0] CODE1 = 3'b011;
    localparam logic [2:0] CODE2 = 3'b101;
    localparam logic [2:0] CODE3 = 3'b110;

    // Lock-acquisition state machine
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_e;

endpackage : seq_code_pkg

// File: rtl/seq_code_checker_if.sv
// Signal bundle between the code source (master) and the checker (slave).
// Handshake: code_valid qualifies code_in on the rising clk edge where it is high;
// there is no ready, so the checker accepts every valid code it is offered.
// Every checker output is registered and appears one cycle after the sampling edge;
// index_valid marks the cycles where index_out reflects a freshly sampled code.
interface seq_code_checker_if #(
    parameter int CNT_W = 8
);
    import seq_code_pkg::*;

    logic [2:0]       code_in;
    logic             code_valid;
    logic             err_clr;
    logic [IDX_W-1:0] index_out;
    logic             index_valid;
    logic             locked;
    logic             err_pulse;
    logic             parity_err;
    logic [CNT_W-1:0] err_count;
    state_e           state_dbg;

    modport master (
        output code_in, code_valid, err_clr,
        input  index_out, index_valid, locked, err_pulse, parity_err, err_count, state_dbg
    );

    modport slave (
        input  code_in, code_valid, err_clr,
        output index_out, index_valid, locked, err_pulse, parity_err, err_count, state_dbg
    );

endinterface : seq_code_checker_if

// File: rtl/seq_code_decode.sv
// Combinational decoder: maps a received code to its phase index and reports
// whether the code has even parity. Odd-parity codes decode to index 0.
module seq_code_decode
    import seq_code_pkg::*;
(
    input  logic [2:0]       code_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             parity_ok_o
);

    // Parity check and code-to-phase lookup
    always_comb begin
        parity_ok_o = ~^code_i;
        unique case (code_i)
            CODE0:   idx_o = 2'd0;
            CODE1:   idx_o = 2'd1;
            CODE2:   idx_o = 2'd2;
            CODE3:   idx_o = 2'd3;
            default: idx_o = 2'd0;
        endcase
    end

endmodule : seq_code_decode

// File: rtl/seq_code_checker.sv
// Receive-side monitor for the 3-bit sequence-counter stream.
// Hunts for an even-parity code, confirms LOCK_CNT in-order codes, then runs a
// flywheel expected index while locked, counting mismatches and odd-parity codes
// in a saturating error counter. LOSS_CNT consecutive errors drop lock.
module seq_code_checker
    import seq_code_pkg::*;
#(
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 2,
    parameter int CNT_W    = 8
) (
    input  logic         clk,
    input  logic         reset,
    seq_code_checker_if.slave bus
);

    // Counters only need to reach their thresholds
    localparam int MW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam int SW = (LOSS_CNT < 2) ? 1 : $clog2(LOSS_CNT + 1);
    localparam logic [MW-1:0] LOCK_V = MW'(LOCK_CNT);
    localparam logic [SW-1:0] LOSS_V = SW'(LOSS_CNT);

    logic [IDX_W-1:0] idx;
    logic             parity_ok;

    state_e           state_q, state_d;
    logic [MW-1:0]    match_q, match_d, match_inc;
    logic [SW-1:0]    miss_q, miss_d, miss_inc;
    logic [IDX_W-1:0] exp_q, exp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_hit;

    logic [IDX_W-1:0] idx_out_q;
    logic             idx_vld_q;
    logic             locked_q;
    logic             err_pulse_q;
    logic             parity_err_q;

    seq_code_decode u_decode (
        .code_i      (bus.code_in),
        .idx_o       (idx),
        .parity_ok_o (parity_ok)
    );

    assign match_inc = match_q + MW'(1);
    assign miss_inc  = miss_q + SW'(1);

    // Next-state logic for the lock FSM, its counters and the flywheel index
    always_comb begin
        state_d = state_q;
        match_d = match_q;
        miss_d  = miss_q;
        exp_d   = exp_q;
        err_hit = 1'b0;
        if (bus.code_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (parity_ok) begin
                        match_d = MW'(1);
                        miss_d  = '0;
                        exp_d   = idx + IDX_W'(1);
                        state_d = (LOCK_CNT == 1) ? LOCKED : SYNC;
                    end
                end
                SYNC: begin
                    if (!parity_ok) begin
                        match_d = '0;
                        state_d = HUNT;
                    end else if (idx == exp_q) begin
                        match_d = match_inc;
                        exp_d   = exp_q + IDX_W'(1);
                        if (match_inc == LOCK_V) begin
                            miss_d  = '0;
                            state_d = LOCKED;
                        end
                    end else begin
                        // In-order run broken: this code starts a new run
                        match_d = MW'(1);
                        exp_d   = idx + IDX_W'(1);
                    end
                end
                LOCKED: begin
                    // Flywheel: expected advances regardless of what arrived
                    exp_d = exp_q + IDX_W'(1);
                    if (parity_ok && idx == exp_q) begin
                        miss_d = '0;
                    end else begin
                        err_hit = 1'b1;
                        miss_d  = miss_inc;
                        if (miss_inc == LOSS_V) begin
                            miss_d  = '0;
                            match_d = '0;
                            state_d = HUNT;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // Saturating error counter; a clear wins over a same-cycle increment
    always_comb begin
        cnt_d = cnt_q;
        if (bus.err_clr) begin
            cnt_d = '0;
        end else if (err_hit && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= HUNT;
            match_q      <= '0;
            miss_q       <= '0;
            exp_q        <= '0;
            cnt_q        <= '0;
            idx_out_q    <= '0;
            idx_vld_q    <= 1'b0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            match_q      <= match_d;
            miss_q       <= miss_d;
            exp_q        <= exp_d;
            cnt_q        <= cnt_d;
            idx_vld_q    <= bus.code_valid;
            locked_q     <= (state_d == LOCKED);
            err_pulse_q  <= err_hit;
            parity_err_q <= bus.code_valid & ~parity_ok;
            if (bus.code_valid) begin
                idx_out_q <= idx;
            end
        end
    end

    assign bus.index_out   = idx_out_q;
    assign bus.index_valid = idx_vld_q;
    assign bus.locked      = locked_q;
    assign bus.err_pulse   = err_pulse_q;
    assign bus.parity_err  = parity_err_q;
    assign bus.err_count   = cnt_q;
    assign bus.state_dbg   = state_q;

endmodule : seq_code_checker
